// File: rtl/temp_alarm_monitor.sv
// rtl/temp_alarm_monitor.sv - debounced hysteretic over-temperature alarm with peak and entry count (option: TEMP_ALARM_LATCH_EN)
module temp_alarm_monitor #(
  parameter logic signed [7:0] HIGH_THR = 8'sd60,
  parameter logic signed [7:0] LOW_THR  = 8'sd50,
  parameter int unsigned       DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] temp_i,
  input  logic       valid_i,
  input  logic       clear_i,
  output logic       alarm_o,
  output logic [1:0] state_o,
  output logic [7:0] peak_o,
  output logic [7:0] alarm_cnt_o
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

`ifdef TEMP_ALARM_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PENDING = 2'd1,
    ST_ALARM   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [3:0]         w_next_cnt;
  logic [3:0]         w_cnt_inc;
  logic               w_entry;
  logic               w_hot;
  logic               w_cool;
  logic               w_fsm_clear;
  logic signed [7:0]  w_temp;
  logic               r_alarm;
  logic signed [7:0]  r_peak;
  logic [7:0]         r_alarm_cnt;

  assign w_temp      = $signed(temp_i);
  assign w_hot       = valid_i && (w_temp > HIGH_THR);
  assign w_cool      = valid_i && (w_temp < LOW_THR);
  assign w_cnt_inc   = r_cnt + 4'd1;
  // In latching mode clear_i owns the FSM and suppresses sample evaluation
  assign w_fsm_clear = LATCH_EN && clear_i;

  // Next-state and debounce counter; counter restarts on every state change
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_entry      = 1'b0;
    if (w_fsm_clear) begin
      w_next_state = ST_NORMAL;
      w_next_cnt   = 4'd0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (w_hot) begin
            if (DEB == 4'd1) begin
              w_next_state = ST_ALARM;
              w_next_cnt   = 4'd0;
              w_entry      = 1'b1;
            end else begin
              w_next_state = ST_PENDING;
              w_next_cnt   = 4'd1;
            end
          end
        end
        ST_PENDING: begin
          if (valid_i) begin
            if (w_hot) begin
              if (w_cnt_inc == DEB) begin
                w_next_state = ST_ALARM;
                w_next_cnt   = 4'd0;
                w_entry      = 1'b1;
              end else begin
                w_next_cnt = w_cnt_inc;
              end
            end else begin
              w_next_state = ST_NORMAL;
              w_next_cnt   = 4'd0;
            end
          end
        end
        ST_ALARM: begin
          if (!LATCH_EN && w_cool) begin
            if (DEB == 4'd1) begin
              w_next_state = ST_NORMAL;
              w_next_cnt   = 4'd0;
            end else begin
              w_next_state = ST_RECOVER;
              w_next_cnt   = 4'd1;
            end
          end
        end
        ST_RECOVER: begin
          if (valid_i) begin
            if (w_cool) begin
              if (w_cnt_inc == DEB) begin
                w_next_state = ST_NORMAL;
                w_next_cnt   = 4'd0;
              end else begin
                w_next_cnt = w_cnt_inc;
              end
            end else begin
              w_next_state = ST_ALARM;
              w_next_cnt   = 4'd0;
            end
          end
        end
        default: begin
          w_next_state = ST_NORMAL;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

  // State, debounce counter and registered alarm flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_NORMAL;
      r_cnt   <= 4'd0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_alarm <= (w_next_state == ST_ALARM) || (w_next_state == ST_RECOVER);
    end
  end

  // Peak tracker; clear restarts from -128, or from the coincident sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_peak <= -8'sd128;
    end else if (clear_i) begin
      r_peak <= valid_i ? w_temp : -8'sd128;
    end else if (valid_i && (w_temp > r_peak)) begin
      r_peak <= w_temp;
    end
  end

  // Saturating count of alarm entries from NORMAL/PENDING
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alarm_cnt <= 8'd0;
    end else if (clear_i) begin
      r_alarm_cnt <= w_entry ? 8'd1 : 8'd0;
    end else if (w_entry && (r_alarm_cnt != 8'hFF)) begin
      r_alarm_cnt <= r_alarm_cnt + 8'd1;
    end
  end

  assign alarm_o     = r_alarm;
  assign state_o     = r_state;
  assign peak_o      = r_peak;
  assign alarm_cnt_o = r_alarm_cnt;

endmodule

// File: doc/temp_alarm_monitor.md
# temp_alarm_monitor

Downstream consumer of the moving-average stage: takes the registered signed 8-bit average temperature and raises a debounced, hysteretic over-temperature alarm. It also tracks the peak average seen and counts alarm entries for status readout. Purely synchronous, single clock domain.

## Interface
- HIGH_THR, 60: signed 8-bit alarm-entry threshold. A sample qualifies when strictly greater.
- LOW_THR, 50: signed 8-bit recovery threshold. A sample qualifies when strictly less. Constraint: LOW_THR <= HIGH_THR.
- DEBOUNCE, 4: consecutive qualifying samples required for a transition. Legal range 1..15.

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  reset, asynchronous, active-high
- temp_i  in  8  signed two's-complement average temperature from the averaging stage
- valid_i  in  1  temp_i holds a new sample this cycle
- clear_i  in  1  status clear, single-cycle pulse
- alarm_o  out  1  over-temperature alarm, registered
- state_o  out  2  FSM state: 0 NORMAL, 1 PENDING, 2 ALARM, 3 RECOVER
- peak_o  out  8  signed maximum of valid samples since reset/clear
- alarm_cnt_o  out  8  count of ALARM entries, saturating at 255

## Operation
- All comparisons are signed 8-bit. Cycles without valid_i are ignored. They neither advance nor reset the debounce counter.
- Debounce counter: 4 bits, internal, zeroed on every state change.
- NORMAL: a valid sample > HIGH_THR goes to PENDING with cnt=1. If DEBOUNCE==1, it goes directly to ALARM.
- PENDING:
  - Valid sample > HIGH_THR: cnt++. When cnt reaches DEBOUNCE, go to ALARM.
  - Valid sample <= HIGH_THR: go to NORMAL.
- ALARM: a valid sample < LOW_THR goes to RECOVER with cnt=1. If DEBOUNCE==1, it goes directly to NORMAL.
- RECOVER:
  - Valid sample < LOW_THR: cnt++. When cnt reaches DEBOUNCE, go to NORMAL.
  - Valid sample >= LOW_THR: go to ALARM.
- alarm_o = 1 in ALARM and RECOVER, else 0.
- alarm_cnt_o increments on each entry into ALARM from PENDING or NORMAL. A RECOVER->ALARM bounce does not count. It holds at 255.
- peak_o:
  - On valid_i, loads temp_i if temp_i > peak_o.
  - clear_i resets peak_o to 0x80 (-128) and alarm_cnt_o to 0.
  - clear_i together with valid_i loads temp_i into peak_o.

## Timing
- Reset values: state NORMAL, cnt 0, alarm_o 0, state_o 0, peak_o 0x80, alarm_cnt_o 0.
- Reset asserted mid-operation returns all of the above immediately and asynchronously.
- All outputs are registered. A transition caused by the sample at edge N is visible on the outputs after edge N.
  - Example: with DEBOUNCE=4 and back-to-back valid hot samples, alarm_o rises one cycle after the 4th sample is presented.
- Simultaneous clear_i and a state-changing sample: the FSM follows the sample; clear_i affects only the counters (macro absent).

## Configuration
- TEMP_ALARM_LATCH_EN defined:
  - In ALARM, recovery samples are ignored. The block never enters RECOVER, and alarm_o stays 1.
  - clear_i in ALARM returns the FSM to NORMAL with alarm_o 0 on the next cycle, and also clears peak_o and alarm_cnt_o.
  - clear_i wins over a simultaneous valid sample for the FSM; that sample is not evaluated for state.
- Macro absent: the hysteresis/RECOVER behaviour above applies, and clear_i does not affect the FSM.

## Test plan
- Reset, then valid samples 70,70,70,70 on consecutive cycles -> state_o 1,1,1 then 2; alarm_o rises after the 4th edge; alarm_cnt_o=1; peak_o=70.
- Samples 70,70,55,70 -> returns to NORMAL at 55; alarm_o stays 0; peak_o=70.
- From ALARM, samples 40,40,40,40 -> RECOVER then NORMAL; alarm_o falls after the 4th edge. Samples 40,55 -> back to ALARM, alarm_cnt_o unchanged.
- Hot samples 70 separated by idle cycles (valid_i=0) -> alarm still asserted after the 4th valid sample. Negative samples -20 keep peak_o correctly signed.
- rst_i asserted while in RECOVER -> all outputs at reset values immediately, including peak_o=0x80.
- TEMP_ALARM_LATCH_EN defined: reach ALARM, feed 40 x6 -> alarm_o stays 1. Pulse clear_i -> state_o 0, alarm_o 0, alarm_cnt_o 0, peak_o 0x80 next cycle.
